sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO written in plain RTL, replacing the vendor FIFO IP between the fifo_write and fifo_read engines in the FIFO test design.
- Adds the following, all of which the IP instance lacks:
  - configurable width and depth;
  - programmable almost_full and almost_empty thresholds;
  - a first-word-fall-through (FWFT) mode;
  - sticky-free overflow and underflow error pulses;
  - a single occupancy count shared by the read and write sides.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/sdp_ram.sv | 51 +++++
 rtl/sync_fifo_param.sv | 91 +++++++++
 tb/tb_sync_fifo_param.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Imported by the FIFO top level and its storage sub-module.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port memory: synchronous write, registered or async read.
// Contents are never reset; only the registered read output is.
module sdp_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 1 << DEF_ADDR_W,
    parameter int REG_RD = 1,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (REG_RD != 0) begin : g_reg_rd
            logic [DATA_W-1:0] q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else if (rd_en) begin
                    q <= mem[rd_addr];
                end
            end

            assign rd_data = q;
        end else begin : g_async_rd
            // Head word falls through; reset and read enable play no part.
            logic unused_rd_ctl;

            assign unused_rd_ctl = rst ^ rd_en;
            assign rd_data       = mem[rd_addr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with shared occupancy count, threshold flags,
// error pulses and optional first-word-fall-through read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AF_THRESH = (1 << ADDR_W) - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FIFO_STD
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   data_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int CW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = CW'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = CW'(AE_THRESH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic [ADDR_W:0]   count_next;

    // Acceptance looks only at registered flags: no full/empty bypass.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign count_next = data_count
                      + CW'(wr_acc)
                      - CW'(rd_acc);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            data_count   <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            data_count   <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

    sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .REG_RD ((FWFT == FIFO_FWFT) ? 0 : 1)
    ) u_ram (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (dout)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: standard-mode and FWFT instances
// sharing one clock and reset, DEPTH 16, AF 14, AE 2.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;

    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic [4:0] cnt;
    logic       ovf;
    logic       unf;

    logic       f_wr_en;
    logic [7:0] f_din;
    logic       f_rd_en;
    logic [7:0] f_dout;
    logic       f_full;
    logic       f_empty;
    logic       f_af;
    logic       f_ae;
    logic [4:0] f_cnt;
    logic       f_ovf;
    logic       f_unf;

    int checks;
    int failures;

    sync_fifo_param #(
        .DATA_W    (8),
        .ADDR_W    (4),
        .AF_THRESH (14),
        .AE_THRESH (2),
        .FWFT      (0)
    ) u_std (
        .sys_clk      (clk),
        .sys_rst      (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (af),
        .almost_empty (ae),
        .data_count   (cnt),
        .overflow     (ovf),
        .underflow    (unf)
    );

    sync_fifo_param #(
        .DATA_W    (8),
        .ADDR_W    (4),
        .AF_THRESH (14),
        .AE_THRESH (2),
        .FWFT      (1)
    ) u_fwft (
        .sys_clk      (clk),
        .sys_rst      (rst),
        .wr_en        (f_wr_en),
        .din          (f_din),
        .rd_en        (f_rd_en),
        .dout         (f_dout),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_af),
        .almost_empty (f_ae),
        .data_count   (f_cnt),
        .overflow     (f_ovf),
        .underflow    (f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_std_reset(input string tag);
        check({tag, "_cnt"}, 32'(cnt), 32'd0);
        check({tag, "_flags"}, {28'd0, full, empty, af, ae}, 32'b0101);
        check({tag, "_err"}, {30'd0, ovf, unf}, 32'd0);
        check({tag, "_dout"}, 32'(dout), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = 8'h00;
        f_wr_en  = 1'b0;
        f_rd_en  = 1'b0;
        f_din    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_std_reset("reset");
        check("reset_fwft_empty", 32'(f_empty), 32'd1);
        rst = 1'b0;

        // 1a. fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            din   = 8'(i);
            tick();
            check("fill_cnt", 32'(cnt), 32'(i + 1));
            check("fill_full", 32'(full), 32'((i + 1) == 16));
            check("fill_af", 32'(af), 32'((i + 1) >= 14));
            check("fill_ae", 32'(ae), 32'((i + 1) <= 2));
            check("fill_empty", 32'(empty), 32'd0);
        end

        // 2. overflow while full
        din = 8'hAA;
        tick();
        check("ovf_pulse", 32'(ovf), 32'd1);
        check("ovf_cnt", 32'(cnt), 32'd16);
        wr_en = 1'b0;
        tick();
        check("ovf_clear", 32'(ovf), 32'd0);
        check("ovf_cnt2", 32'(cnt), 32'd16);

        // 1b. drain; 0xAA must never show up
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            check("drain_dout", 32'(dout), 32'(i));
            check("drain_cnt", 32'(cnt), 32'(15 - i));
            check("drain_empty", 32'(empty), 32'(i == 15));
            check("drain_ae", 32'(ae), 32'((15 - i) <= 2));
            check("drain_af", 32'(af), 32'((15 - i) >= 14));
        end
        rd_en = 1'b0;

        // 3. read+write together while empty
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 8'h3C;
        tick();
        check("unf_pulse", 32'(unf), 32'd1);
        check("unf_cnt", 32'(cnt), 32'd1);
        check("unf_empty", 32'(empty), 32'd0);
        check("unf_dout_hold", 32'(dout), 32'h0F);
        wr_en = 1'b0;
        tick();
        check("unf_read", 32'(dout), 32'h3C);
        check("unf_clear", 32'(unf), 32'd0);
        check("unf_cnt2", 32'(cnt), 32'd0);
        rd_en = 1'b0;

        // 4. steady state at count 8 across pointer wrap
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            din   = 8'h40 + 8'(i);
            tick();
        end
        check("mid_cnt", 32'(cnt), 32'd8);
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            din   = 8'h48 + 8'(k);
            tick();
            check("mid_dout", 32'(dout), 32'h40 + 32'(k));
            check("mid_cnt_hold", 32'(cnt), 32'd8);
            check("mid_flags", {28'd0, full, empty, af, ae}, 32'd0);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_en = 1'b1;
            tick();
            check("mid_tail", 32'(dout), 32'h54 + 32'(k));
        end
        rd_en = 1'b0;
        check("mid_empty", 32'(empty), 32'd1);

        // 5. FWFT: head word visible without a read
        f_wr_en = 1'b1;
        f_din   = 8'h5A;
        tick();
        f_wr_en = 1'b0;
        check("fwft_dout", 32'(f_dout), 32'h5A);
        check("fwft_empty", 32'(f_empty), 32'd0);
        check("fwft_cnt", 32'(f_cnt), 32'd1);
        tick();
        check("fwft_hold", 32'(f_dout), 32'h5A);
        f_wr_en = 1'b1;
        f_din   = 8'hA7;
        tick();
        f_wr_en = 1'b0;
        check("fwft_head", 32'(f_dout), 32'h5A);
        f_rd_en = 1'b1;
        tick();
        check("fwft_next", 32'(f_dout), 32'hA7);
        check("fwft_cnt1", 32'(f_cnt), 32'd1);
        tick();
        f_rd_en = 1'b0;
        check("fwft_pop_empty", 32'(f_empty), 32'd1);
        check("fwft_pop_cnt", 32'(f_cnt), 32'd0);

        // 6. async reset with 9 stored words
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1;
            din   = 8'h60 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("pre_rst_cnt", 32'(cnt), 32'd9);
        check("pre_rst_dout", 32'(dout), 32'h5B);
        #3;
        rst = 1'b1;
        #1;
        check_std_reset("async_rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        wr_en = 1'b1;
        din   = 8'h77;
        tick();
        check("post_rst_cnt", 32'(cnt), 32'd1);
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("post_rst_dout", 32'(dout), 32'h77);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
